// File: rtl/ir_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, field
// positions inside the 16-bit instruction word, and opcode values for the controller.
package ir_fetch_pkg;

    localparam int INSTR_W  = 16;
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 13;
    localparam int ADDR_MSB = 12;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_HI = 2'd1,
        FETCH_LO = 2'd2
    } fetch_state_t;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

endpackage

// File: rtl/ir_fetch.sv
// Instruction fetch: reads a 16-bit instruction as two bytes (high then low),
// splits it into opcode and operand address, and steps the PC once per byte.
module ir_fetch
    import ir_fetch_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_start,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    output logic              pc_step,
    output logic [OP_W-1:0]   opcode,
    output logic [ADDR_W-1:0] ir_addr,
    output logic              ir_valid,
    output logic              busy
);

    localparam int WORD_W = 2 * DATA_W;

    fetch_state_t      state;
    logic [ADDR_W-1:0] base;
    logic [WORD_W-1:0] ir;
    logic [WORD_W-1:0] word_next;

    // The completed word as it will look once the low byte lands this cycle.
    assign word_next = {ir[WORD_W-1:DATA_W], mem_data};

    // NOTE: every state element is assigned with <= so all registers update
    // together from pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base     <= '0;
            ir       <= '0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            pc_step  <= 1'b0;
            opcode   <= '0;
            ir_addr  <= '0;
            ir_valid <= 1'b0;
            busy     <= 1'b0;
        end else if (flush) begin
            // Abort wins over any byte arriving now; the last decoded instruction is kept.
            state    <= IDLE;
            mem_rd   <= 1'b0;
            pc_step  <= 1'b0;
            ir_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            pc_step <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_start) begin
                        base     <= pc_addr;
                        mem_addr <= pc_addr;
                        mem_rd   <= 1'b1;
                        ir_valid <= 1'b0;
                        busy     <= 1'b1;
                        state    <= FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    if (mem_ready) begin
                        ir[WORD_W-1:DATA_W] <= mem_data;
                        mem_addr            <= base + ADDR_W'(1);
                        pc_step             <= 1'b1;
                        state               <= FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (mem_ready) begin
                        ir[DATA_W-1:0] <= mem_data;
                        opcode         <= word_next[WORD_W-1 -: OP_W];
                        ir_addr        <= word_next[ADDR_W-1:0];
                        pc_step        <= 1'b1;
                        mem_rd         <= 1'b0;
                        ir_valid       <= 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    mem_rd <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // A decoded instruction must not change underneath the controller.
    a_ir_stable: assert property (@(posedge clk) disable iff (rst)
        (ir_valid && !rst) |=> ($stable(opcode) && $stable(ir_addr)));

    a_busy_tracks_state: assert property (@(posedge clk) disable iff (rst)
        busy == (state != IDLE));

endmodule

// File: tb/tb_ir_fetch.sv
// Directed bench for ir_fetch: a byte memory model answers reads, a scoreboard
// queue holds expected instructions and a monitor checks each ir_valid rise.
`timescale 1ns/1ps
module tb_ir_fetch;
    import ir_fetch_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 13;
    localparam int OP_W   = 3;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    logic              clk = 1'b0;
    logic              rst, fetch_start, flush, mem_ready;
    logic [ADDR_W-1:0] pc_addr, mem_addr, ir_addr;
    logic              mem_rd, pc_step, ir_valid, busy;
    logic [DATA_W-1:0] mem_data;
    logic [OP_W-1:0]   opcode;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    instr_t            exp_q[$];
    int                n_vec    = 0;
    int                n_err    = 0;
    int                step_cnt = 0;
    logic              valid_q  = 1'b0;

    always #5 clk = ~clk;

    assign mem_data = mem_ready ? mem[mem_addr] : '0;

    ir_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_start(fetch_start),
        .flush      (flush),
        .pc_addr    (pc_addr),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .pc_step    (pc_step),
        .opcode     (opcode),
        .ir_addr    (ir_addr),
        .ir_valid   (ir_valid),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: counts pc_step pulses and scores every completed instruction.
    always @(negedge clk) begin
        instr_t e;
        if (pc_step) step_cnt++;
        if (ir_valid && !valid_q) begin
            check("ir_valid_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_opcode", 32'(opcode), 32'(e.op));
                check("sb_ir_addr", 32'(ir_addr), 32'(e.addr));
            end
        end
        valid_q = ir_valid;
    end

    // One full fetch with `waits` not-ready cycles before each byte.
    task automatic do_fetch(input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] pc_nxt,
                            input logic [7:0] hi, input logic [7:0] lo, input int waits,
                            input logic [OP_W-1:0] exp_op, input logic [ADDR_W-1:0] exp_addr);
        int s0;
        mem[pc]     = hi;
        mem[pc_nxt] = lo;
        exp_q.push_back('{op: exp_op, addr: exp_addr});
        s0          = step_cnt;
        pc_addr     = pc;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_mem_rd", 32'(mem_rd), 32'd1);
        check("start_mem_addr", 32'(mem_addr), 32'(pc));
        check("start_ir_valid", 32'(ir_valid), 32'd0);
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < waits; w++) begin
                mem_ready = 1'b0;
                tick();
                check("wait_pc_step", 32'(pc_step), 32'd0);
                check("wait_mem_addr", 32'(mem_addr), (b == 0) ? 32'(pc) : 32'(pc_nxt));
            end
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
            check("byte_pc_step", 32'(pc_step), 32'd1);
            if (b == 0) begin
                check("hi_mem_addr", 32'(mem_addr), 32'(pc_nxt));
                check("hi_ir_valid", 32'(ir_valid), 32'd0);
            end else begin
                check("lo_ir_valid", 32'(ir_valid), 32'd1);
                check("lo_busy", 32'(busy), 32'd0);
                check("lo_mem_rd", 32'(mem_rd), 32'd0);
            end
        end
        tick();
        check("after_pc_step", 32'(pc_step), 32'd0);
        check("pc_step_count", 32'(step_cnt - s0), 32'd2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        rst         = 1'b1;
        fetch_start = 1'b0;
        flush       = 1'b0;
        mem_ready   = 1'b0;
        pc_addr     = '0;
        tick();
        tick();
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_pc_step", 32'(pc_step), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_ir_addr", 32'(ir_addr), 32'd0);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Zero-wait: 0xA123 -> opcode 101, ir_addr 0x0123.
        do_fetch(13'h0040, 13'h0041, 8'hA1, 8'h23, 0, 3'b101, 13'h0123);
        // Three wait states per byte: 0xFFFF -> 111 / 0x1FFF, ir_valid after N+8.
        do_fetch(13'h0100, 13'h0101, 8'hFF, 8'hFF, 3, 3'b111, 13'h1FFF);
        // Address wrap: 0x4567 -> 010 / 0x0567, second byte read at 0x0000.
        do_fetch(13'h1FFF, 13'h0000, 8'h45, 8'h67, 1, 3'b010, 13'h0567);

        // fetch_start held high: ignored while busy, restarts one cycle after completion.
        mem[13'h0300] = 8'hE0;
        mem[13'h0301] = 8'h05;
        exp_q.push_back('{op: 3'b111, addr: 13'h0005});
        exp_q.push_back('{op: 3'b111, addr: 13'h0005});
        pc_addr     = 13'h0300;
        fetch_start = 1'b1;
        mem_ready   = 1'b1;
        tick();
        tick();
        check("held_mid_busy", 32'(busy), 32'd1);
        tick();
        check("held_done_busy", 32'(busy), 32'd0);
        check("held_done_valid", 32'(ir_valid), 32'd1);
        tick();
        fetch_start = 1'b0;
        check("held_restart_busy", 32'(busy), 32'd1);
        check("held_restart_valid", 32'(ir_valid), 32'd0);
        check("held_restart_addr", 32'(mem_addr), 32'h0300);
        tick();
        tick();
        mem_ready = 1'b0;
        check("held_second_valid", 32'(ir_valid), 32'd1);
        tick();

        // Flush in FETCH_LO with a byte arriving: byte dropped, old instruction kept.
        mem[13'h0200] = 8'h12;
        mem[13'h0201] = 8'h34;
        s0            = step_cnt;
        pc_addr       = 13'h0200;
        fetch_start   = 1'b1;
        mem_ready     = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        mem_ready = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_ir_valid", 32'(ir_valid), 32'd0);
        check("flush_mem_rd", 32'(mem_rd), 32'd0);
        check("flush_pc_step", 32'(pc_step), 32'd0);
        check("flush_opcode", 32'(opcode), 32'd7);
        check("flush_ir_addr", 32'(ir_addr), 32'h0005);
        tick();
        check("flush_step_count", 32'(step_cnt - s0), 32'd1);

        // flush and fetch_start together in IDLE: no fetch starts.
        fetch_start = 1'b1;
        flush       = 1'b1;
        tick();
        fetch_start = 1'b0;
        flush       = 1'b0;
        check("both_busy", 32'(busy), 32'd0);
        check("both_mem_rd", 32'(mem_rd), 32'd0);
        tick();
        check("both_still_idle", 32'(busy), 32'd0);

        // Reset during FETCH_LO with a byte arriving: everything clears.
        mem[13'h0050] = 8'hAB;
        mem[13'h0051] = 8'hCD;
        s0            = step_cnt;
        pc_addr       = 13'h0050;
        fetch_start   = 1'b1;
        mem_ready     = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        mem_ready = 1'b0;
        check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
        check("mid_rst_pc_step", 32'(pc_step), 32'd0);
        check("mid_rst_opcode", 32'(opcode), 32'd0);
        check("mid_rst_ir_addr", 32'(ir_addr), 32'd0);
        check("mid_rst_ir_valid", 32'(ir_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        check("mid_rst_idle", 32'(busy), 32'd0);
        check("mid_rst_step_count", 32'(step_cnt - s0), 32'd1);

        // Normal fetch after reset: 0x2001 -> 001 / 0x0001.
        do_fetch(13'h0060, 13'h0061, 8'h20, 8'h01, 0, 3'b001, 13'h0001);

        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ir_fetch.md
Name: ir_fetch

Overview:
- Instruction fetch stage between the program counter and the controller/ALU of the toy processor.
- Reads one 16-bit instruction as two bytes (high, then low) over the 8-bit memory bus.
- Splits the instruction into a 3-bit opcode and a 13-bit operand address; the operand address feeds the counter's ir_addr load path.
- Issues pc_step pulses so the counter advances once per byte consumed.

Parameters:
- DATA_W, 8: memory data bus width.
- ADDR_W, 13: instruction/memory address width, matches pc_addr.
- OP_W, 3: opcode width. Requires OP_W + ADDR_W = 2*DATA_W.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- fetch_start  in  1  controller requests the next instruction; honoured only in IDLE.
- flush  in  1  abort the fetch in progress (jump/branch taken).
- pc_addr  in  ADDR_W  current program counter value.
- mem_addr  out  ADDR_W  byte address presented to memory.
- mem_rd  out  1  memory read strobe.
- mem_data  in  DATA_W  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory has valid data this cycle.
- pc_step  out  1  one-cycle pulse per byte accepted; drives the counter increment.
- opcode  out  OP_W  instruction bits [15:13].
- ir_addr  out  ADDR_W  instruction bits [12:0], to counter ir_addr.
- ir_valid  out  1  opcode/ir_addr hold a complete instruction.
- busy  out  1  high in FETCH_HI or FETCH_LO.

Behaviour:
- Reset:
  - Synchronous; state=IDLE.
  - mem_addr, mem_rd, pc_step, opcode, ir_addr, ir_valid and busy all 0; internal ir register = 0.
  - rst during FETCH_HI or FETCH_LO aborts immediately. No pc_step is issued and no partial byte is kept.
- Outputs: all registered; no combinational path from input to output.
- FSM states: IDLE, FETCH_HI, FETCH_LO.
- IDLE:
  - fetch_start=1 and flush=0: base <= pc_addr, mem_addr <= pc_addr, mem_rd <= 1, ir_valid <= 0, go to FETCH_HI.
  - Otherwise hold all outputs.
- FETCH_HI:
  - mem_rd=1.
  - mem_ready=0: wait, no timeout.
  - mem_ready=1: ir[15:8] <= mem_data, mem_addr <= base+1, pc_step <= 1, go to FETCH_LO.
- FETCH_LO:
  - mem_ready=1: ir[7:0] <= mem_data, pc_step <= 1, mem_rd <= 0, ir_valid <= 1.
  - On that same edge, opcode/ir_addr update from the full word; go to IDLE.
- pc_step: high exactly one cycle per byte accepted, i.e. two pulses per instruction. With zero-wait memory the two pulses are back-to-back cycles.
- Address arithmetic: base+1 is mod 2^ADDR_W, so 13'h1FFF+1 = 13'h0000. No carry out.
- ir_valid: stays 1 until the next accepted fetch_start or a flush. opcode/ir_addr are stable while ir_valid=1.
- Latency: fetch_start sampled at edge N with zero-wait memory gives ir_valid=1 after edge N+2. Each wait cycle adds one.
- fetch_start in FETCH_HI or FETCH_LO: ignored and not queued.
- flush:
  - Any state: next edge goes to IDLE, mem_rd <= 0, ir_valid <= 0, no pc_step.
  - A byte arriving on the same edge (mem_ready=1) is discarded.
  - opcode/ir_addr keep their old values.
- Simultaneous events:
  - flush and fetch_start together in IDLE: flush wins, no fetch starts.
  - rst outranks flush; flush outranks mem_ready.

Decomposition:
- Shared package/header: fetch state encoding (IDLE=2'd0, FETCH_HI=2'd1, FETCH_LO=2'd2), and the opcode field positions (OP_MSB=15, OP_LSB=13, ADDR_MSB=12).
- Opcode value constants also go in the shared package for use by the controller.
- No sub-module needed. The FSM and the instruction register stay in one module; the split into opcode and ir_addr is plain wiring.

Test Plan:
- Reset mid-fetch: assert rst while in FETCH_LO → next cycle all outputs 0, state IDLE, no pc_step pulse.
- Zero-wait fetch:
  - Stimulus: pc_addr=13'h0040, mem_ready tied 1, data 8'hA1 then 8'h23, pulse fetch_start.
  - Response: mem_addr 0x0040 then 0x0041; pc_step high two consecutive cycles; after edge N+2 ir_valid=1, opcode=3'b101, ir_addr=13'h0123.
- Wait states: mem_ready low 3 cycles before each byte, data 8'hFF/8'hFF → ir_valid after edge N+8, opcode=3'b111, ir_addr=13'h1FFF; pc_step only on ready cycles.
- Wrap: pc_addr=13'h1FFF → second read at mem_addr=13'h0000.
- Flush:
  - Stimulus: assert flush with mem_ready=1 in FETCH_LO.
  - Response: IDLE next cycle, ir_valid=0, only one pc_step issued, opcode/ir_addr keep previous values.
- Ignored request: fetch_start held high through a fetch → exactly one instruction is fetched, then a new fetch starts from IDLE on the following cycle. Simultaneous flush+fetch_start in IDLE → no fetch starts.
